// File: rtl/safe_mode_sync_fsm.sv
// safe_mode_sync_fsm
// Applies a newly programmed safe-mode configuration to the core cluster.
// The sequence is: halt every core through its debug request, run the
// core-state synchronisation handshake, commit the new configuration,
// then release the cores. Every output comes straight from a flop.
module safe_mode_sync_fsm #(
  parameter int NCORES         = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              safe_mode_i,
  input  logic              safe_configuration_i,
  input  logic [2:0]        master_core_i,
  input  logic              critical_section_i,
  input  logic              initial_sync_master_i,
  input  logic [NCORES-1:0] core_halted_i,
  input  logic              sync_done_i,
  input  logic              err_clear_i,
  output logic [NCORES-1:0] debug_req_o,
  output logic              sync_start_o,
  output logic              en_ext_debug_o,
  output logic              sync_busy_o,
  output logic              timeout_err_o,
  output logic              applied_safe_mode_o,
  output logic              applied_safe_cfg_o,
  output logic [2:0]        applied_master_o
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    SYNC,
    RELEASE,
    ERROR
  } state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_init_q;
  logic              r_pending_init;
  logic              r_init_rearm;

  logic              r_tgt_mode;
  logic              r_tgt_cfg;
  logic [2:0]        r_tgt_master;

  logic              r_app_mode;
  logic              r_app_cfg;
  logic [2:0]        r_app_master;

  logic [NCORES-1:0] r_debug_req;
  logic              r_sync_start;
  logic              r_en_ext_debug;
  logic              r_sync_busy;
  logic              r_timeout_err;

  logic              w_master_onehot;
  logic [2:0]        w_req_master;
  logic              w_cfg_change;
  logic              w_init_rise;
  logic              w_timeout;
  logic              w_all_halted;
  logic              w_none_halted;
  logic              w_in_sequence;

  // A malformed master selection keeps the old master, so only the
  // safe_mode/safe_configuration bits can still raise a request.
  assign w_master_onehot = (master_core_i != 3'b000) &&
                           ((master_core_i & (master_core_i - 3'b001)) == 3'b000);
  assign w_req_master    = w_master_onehot ? master_core_i : r_app_master;
  assign w_cfg_change    = {safe_mode_i, safe_configuration_i, w_req_master} !=
                           {r_app_mode, r_app_cfg, r_app_master};

  assign w_init_rise     = initial_sync_master_i & ~r_init_q;
  assign w_timeout       = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_all_halted    = &core_halted_i;
  assign w_none_halted   = (core_halted_i == '0);
  assign w_in_sequence   = (r_state == HALT) || (r_state == SYNC);

  // Sequencer: state, wait counter, latched targets, committed
  // configuration and the registered output decodes of the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_init_q       <= 1'b0;
      r_pending_init <= 1'b0;
      r_init_rearm   <= 1'b0;
      r_tgt_mode     <= 1'b0;
      r_tgt_cfg      <= 1'b0;
      r_tgt_master   <= 3'b001;
      r_app_mode     <= 1'b0;
      r_app_cfg      <= 1'b0;
      r_app_master   <= 3'b001;
      r_debug_req    <= '0;
      r_sync_start   <= 1'b0;
      r_en_ext_debug <= 1'b0;
      r_sync_busy    <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_init_q     <= initial_sync_master_i;
      r_sync_start <= 1'b0;

      // An init-sync edge seen after this sequence already started belongs
      // to the next sequence, so it must survive the clear on RELEASE entry.
      if (w_init_rise) begin
        r_pending_init <= 1'b1;
        if (w_in_sequence) begin
          r_init_rearm <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if ((w_cfg_change || r_pending_init) && !critical_section_i) begin
            r_state        <= HALT;
            r_cnt          <= '0;
            r_tgt_mode     <= safe_mode_i;
            r_tgt_cfg      <= safe_configuration_i;
            r_tgt_master   <= w_req_master;
            r_init_rearm   <= 1'b0;
            r_debug_req    <= '1;
            r_en_ext_debug <= 1'b1;
            r_sync_busy    <= 1'b1;
          end
        end

        HALT: begin
          if (w_all_halted) begin
            r_state      <= SYNC;
            r_cnt        <= '0;
            r_sync_start <= 1'b1;
          end else if (w_timeout) begin
            r_state        <= ERROR;
            r_cnt          <= '0;
            r_debug_req    <= '0;
            r_en_ext_debug <= 1'b0;
            r_timeout_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        SYNC: begin
          if (sync_done_i) begin
            r_state        <= RELEASE;
            r_cnt          <= '0;
            r_app_mode     <= r_tgt_mode;
            r_app_cfg      <= r_tgt_cfg;
            r_app_master   <= r_tgt_master;
            r_debug_req    <= '0;
            r_en_ext_debug <= 1'b0;
            r_pending_init <= r_init_rearm | w_init_rise;
            r_init_rearm   <= 1'b0;
          end else if (w_timeout) begin
            r_state        <= ERROR;
            r_cnt          <= '0;
            r_debug_req    <= '0;
            r_en_ext_debug <= 1'b0;
            r_timeout_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (w_none_halted) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sync_busy <= 1'b0;
          end else if (w_timeout) begin
            r_state       <= ERROR;
            r_cnt         <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ERROR: begin
          if (err_clear_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sync_busy   <= 1'b0;
            r_timeout_err <= 1'b0;
          end
        end

        default: begin
          r_state        <= IDLE;
          r_cnt          <= '0;
          r_debug_req    <= '0;
          r_en_ext_debug <= 1'b0;
          r_sync_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign debug_req_o         = r_debug_req;
  assign sync_start_o        = r_sync_start;
  assign en_ext_debug_o      = r_en_ext_debug;
  assign sync_busy_o         = r_sync_busy;
  assign timeout_err_o       = r_timeout_err;
  assign applied_safe_mode_o = r_app_mode;
  assign applied_safe_cfg_o  = r_app_cfg;
  assign applied_master_o    = r_app_master;

endmodule
